// File: rtl/mem_arbiter.sv
// Byte-serial arbiter between an instruction-fetch port and a load/store port
// sharing one 8-bit synchronous RAM; round-robin on contention, one transaction at a time.
`timescale 1ns/1ps
module mem_arbiter #(
    parameter int ADDR_WIDTH = 17
) (
    input  logic                  clk_in,
    input  logic                  rst_n_in,
    input  logic                  if_req,
    input  logic [ADDR_WIDTH-1:0] if_addr,
    output logic                  if_done,
    output logic [31:0]           if_data,
    input  logic                  ls_req,
    input  logic                  ls_we,
    input  logic [1:0]            ls_size,
    input  logic [ADDR_WIDTH-1:0] ls_addr,
    input  logic [31:0]           ls_wdata,
    output logic                  ls_done,
    output logic [31:0]           ls_rdata,
    output logic                  ram_en,
    output logic                  ram_r_nw,
    output logic [ADDR_WIDTH-1:0] ram_a,
    output logic [7:0]            ram_dout,
    input  logic [7:0]            ram_din
);

    // state | meaning
    // IDLE  | waiting for a request; turnaround cycle while a done pulse is high
    // READ  | issuing read bytes and collecting ram_din one cycle behind
    // WRITE | issuing store bytes, ls_done follows the last one
    typedef enum logic [1:0] {IDLE, READ, WRITE} state_t;

    state_t                r_state, w_state_nxt;
    logic                  r_last_ls, w_last_ls_nxt;
    logic                  r_is_ls, w_is_ls_nxt;
    logic                  r_we, w_we_nxt;
    logic                  r_flush, w_flush_nxt;
    logic [2:0]            r_n, w_n_nxt;
    logic [2:0]            r_cnt, w_cnt_nxt;
    logic [ADDR_WIDTH-1:0] r_addr, w_addr_nxt;
    logic [31:0]           r_wdata, w_wdata_nxt;
    logic [31:0]           r_rbuf, w_rbuf_nxt;
    logic                  r_ram_en, w_ram_en_nxt;
    logic                  r_ram_r_nw, w_ram_r_nw_nxt;
    logic [ADDR_WIDTH-1:0] r_ram_a, w_ram_a_nxt;
    logic [7:0]            r_ram_dout, w_ram_dout_nxt;
    logic                  r_if_done, w_if_done_nxt;
    logic                  r_ls_done, w_ls_done_nxt;
    logic [31:0]           r_if_data, w_if_data_nxt;
    logic [31:0]           r_ls_rdata, w_ls_rdata_nxt;

    logic                  w_grant_ls;
    logic [2:0]            w_ls_n;
    logic [2:0]            w_cnt_inc;
    logic [1:0]            w_wr_lane;
    logic [1:0]            w_cap_lane;
    logic [7:0]            w_wbyte;
    logic [ADDR_WIDTH-1:0] w_addr_sel;

    assign w_grant_ls = ls_req && (!if_req || !r_last_ls);
    assign w_ls_n     = (ls_size == 2'b00) ? 3'd1 : (ls_size == 2'b01) ? 3'd2 : 3'd4;
    assign w_addr_sel = w_grant_ls ? ls_addr : if_addr;
    assign w_cnt_inc  = r_cnt + 3'd1;
    assign w_wr_lane  = w_cnt_inc[1:0];
    assign w_cap_lane = r_cnt[1:0] - 2'd1;
    assign w_wbyte    = r_wdata[{w_wr_lane, 3'b000} +: 8];

    always_ff @(posedge clk_in) begin
        if (!rst_n_in) begin
            r_state    <= IDLE;
            r_last_ls  <= 1'b0;
            r_is_ls    <= 1'b0;
            r_we       <= 1'b0;
            r_flush    <= 1'b0;
            r_n        <= 3'd0;
            r_cnt      <= 3'd0;
            r_addr     <= '0;
            r_wdata    <= 32'd0;
            r_rbuf     <= 32'd0;
            r_ram_en   <= 1'b0;
            r_ram_r_nw <= 1'b1;
            r_ram_a    <= '0;
            r_ram_dout <= 8'd0;
            r_if_done  <= 1'b0;
            r_ls_done  <= 1'b0;
            r_if_data  <= 32'd0;
            r_ls_rdata <= 32'd0;
        end else begin
            r_state    <= w_state_nxt;
            r_last_ls  <= w_last_ls_nxt;
            r_is_ls    <= w_is_ls_nxt;
            r_we       <= w_we_nxt;
            r_flush    <= w_flush_nxt;
            r_n        <= w_n_nxt;
            r_cnt      <= w_cnt_nxt;
            r_addr     <= w_addr_nxt;
            r_wdata    <= w_wdata_nxt;
            r_rbuf     <= w_rbuf_nxt;
            r_ram_en   <= w_ram_en_nxt;
            r_ram_r_nw <= w_ram_r_nw_nxt;
            r_ram_a    <= w_ram_a_nxt;
            r_ram_dout <= w_ram_dout_nxt;
            r_if_done  <= w_if_done_nxt;
            r_ls_done  <= w_ls_done_nxt;
            r_if_data  <= w_if_data_nxt;
            r_ls_rdata <= w_ls_rdata_nxt;
        end
    end

    always_comb begin
        w_state_nxt    = r_state;
        w_last_ls_nxt  = r_last_ls;
        w_is_ls_nxt    = r_is_ls;
        w_we_nxt       = r_we;
        w_flush_nxt    = r_flush;
        w_n_nxt        = r_n;
        w_cnt_nxt      = r_cnt;
        w_addr_nxt     = r_addr;
        w_wdata_nxt    = r_wdata;
        w_rbuf_nxt     = r_rbuf;
        w_ram_en_nxt   = 1'b0;
        w_ram_r_nw_nxt = 1'b1;
        w_ram_a_nxt    = r_ram_a;
        w_ram_dout_nxt = r_ram_dout;
        w_if_done_nxt  = 1'b0;
        w_ls_done_nxt  = 1'b0;
        w_if_data_nxt  = r_if_data;
        w_ls_rdata_nxt = r_ls_rdata;

        case (r_state)
            IDLE: begin
                // a high done pulse marks the turnaround cycle: no acceptance
                if (!r_if_done && !r_ls_done && (if_req || ls_req)) begin
                    w_is_ls_nxt    = w_grant_ls;
                    w_last_ls_nxt  = w_grant_ls;
                    w_we_nxt       = w_grant_ls && ls_we;
                    w_n_nxt        = w_grant_ls ? w_ls_n : 3'd4;
                    w_addr_nxt     = w_addr_sel;
                    w_wdata_nxt    = ls_wdata;
                    w_cnt_nxt      = 3'd0;
                    w_rbuf_nxt     = 32'd0;
                    w_flush_nxt    = 1'b0;
                    w_ram_en_nxt   = 1'b1;
                    w_ram_a_nxt    = w_addr_sel;
                    if (w_grant_ls && ls_we) begin
                        w_ram_r_nw_nxt = 1'b0;
                        w_ram_dout_nxt = ls_wdata[7:0];
                        w_state_nxt    = WRITE;
                    end else begin
                        w_state_nxt    = READ;
                    end
                end
            end
            WRITE: begin
                if (r_cnt == r_n - 3'd1) begin
                    w_ls_done_nxt  = 1'b1;
                    w_state_nxt    = IDLE;
                end else begin
                    w_ram_en_nxt   = 1'b1;
                    w_ram_r_nw_nxt = 1'b0;
                    w_ram_a_nxt    = r_addr + ADDR_WIDTH'(w_cnt_inc);
                    w_ram_dout_nxt = w_wbyte;
                    w_cnt_nxt      = w_cnt_inc;
                end
            end
            READ: begin
                if (w_cnt_inc < r_n) begin
                    w_ram_en_nxt = 1'b1;
                    w_ram_a_nxt  = r_addr + ADDR_WIDTH'(w_cnt_inc);
                end
                // ram_din lags the issued address by one cycle
                if (r_cnt != 3'd0) begin
                    w_rbuf_nxt[{w_cap_lane, 3'b000} +: 8] = ram_din;
                end
                if (!r_is_ls && !if_req) begin
                    w_flush_nxt = 1'b1;
                end
                w_cnt_nxt = w_cnt_inc;
                if (r_cnt == r_n) begin
                    w_state_nxt = IDLE;
                    if (r_is_ls) begin
                        w_ls_rdata_nxt = w_rbuf_nxt;
                        w_ls_done_nxt  = 1'b1;
                    end else if (!w_flush_nxt) begin
                        w_if_data_nxt  = w_rbuf_nxt;
                        w_if_done_nxt  = 1'b1;
                    end
                end
            end
            default: w_state_nxt = IDLE;
        endcase
    end

    assign if_done  = r_if_done;
    assign if_data  = r_if_data;
    assign ls_done  = r_ls_done;
    assign ls_rdata = r_ls_rdata;
    assign ram_en   = r_ram_en;
    assign ram_r_nw = r_ram_r_nw;
    assign ram_a    = r_ram_a;
    assign ram_dout = r_ram_dout;

endmodule

// File: tb/tb_mem_arbiter.sv
// Scoreboard bench for mem_arbiter: a byte-array RAM model on the bus, a reference
// memory image predicting read data, done cycles and round-robin order.
`timescale 1ns/1ps
module tb_mem_arbiter;
    localparam int AW  = 17;
    localparam int MEM = 1 << AW;

    logic          clk_in = 1'b0;
    logic          rst_n_in = 1'b0;
    logic          if_req = 1'b0;
    logic [AW-1:0] if_addr = '0;
    logic          if_done;
    logic [31:0]   if_data;
    logic          ls_req = 1'b0;
    logic          ls_we = 1'b0;
    logic [1:0]    ls_size = 2'b00;
    logic [AW-1:0] ls_addr = '0;
    logic [31:0]   ls_wdata = 32'd0;
    logic          ls_done;
    logic [31:0]   ls_rdata;
    logic          ram_en;
    logic          ram_r_nw;
    logic [AW-1:0] ram_a;
    logic [7:0]    ram_dout;
    logic [7:0]    ram_din;

    logic [7:0] ram     [MEM];
    logic [7:0] ref_mem [MEM];

    int cyc;
    int n_cmp = 0;
    int n_bad = 0;

    typedef struct {
        bit          is_ls;
        logic [31:0] if_d;
        logic [31:0] ls_d;
        int          cyc;
    } exp_t;
    exp_t sbq[$];

    bit          last_ls = 1'b0;
    logic [31:0] m_if_data = 32'd0;
    logic [31:0] m_ls_rdata = 32'd0;

    mem_arbiter #(.ADDR_WIDTH(AW)) dut (
        .clk_in(clk_in), .rst_n_in(rst_n_in),
        .if_req(if_req), .if_addr(if_addr), .if_done(if_done), .if_data(if_data),
        .ls_req(ls_req), .ls_we(ls_we), .ls_size(ls_size), .ls_addr(ls_addr),
        .ls_wdata(ls_wdata), .ls_done(ls_done), .ls_rdata(ls_rdata),
        .ram_en(ram_en), .ram_r_nw(ram_r_nw), .ram_a(ram_a),
        .ram_dout(ram_dout), .ram_din(ram_din)
    );

    always #5 clk_in = ~clk_in;

    always @(posedge clk_in) cyc <= cyc + 1;

    // synchronous RAM: read-first, data valid the cycle after the address edge
    always @(posedge clk_in) begin
        if (ram_en) begin
            ram_din <= ram[ram_a];
            if (!ram_r_nw) ram[ram_a] = ram_dout;
        end
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got 0x%08h want 0x%08h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // monitor: every done pulse must match the oldest expectation
    always @(negedge clk_in) begin
        exp_t e;
        if (if_done || ls_done) begin
            if (if_done && ls_done) begin
                n_cmp++; n_bad++;
                $display("FAIL done_exclusive: both dones high (cycle %0d)", cyc);
            end
            if (sbq.size() == 0) begin
                n_cmp++; n_bad++;
                $display("FAIL unexpected_done: if_done=%0b ls_done=%0b with nothing pending (cycle %0d)",
                         if_done, ls_done, cyc);
            end else begin
                e = sbq.pop_front();
                chk("done_requester", {31'd0, ls_done}, {31'd0, e.is_ls});
                chk("done_cycle", cyc, e.cyc);
                chk("if_data", if_data, e.if_d);
                chk("ls_rdata", ls_rdata, e.ls_d);
            end
        end
    end

    function automatic int size_n(input logic [1:0] s);
        return (s == 2'b00) ? 1 : (s == 2'b01) ? 2 : 4;
    endfunction

    function automatic int wrap(input logic [AW-1:0] a, input int i);
        return (int'(a) + i) % MEM;
    endfunction

    function automatic logic [31:0] ref_read(input logic [AW-1:0] a, input int n);
        logic [31:0] v = 32'd0;
        for (int i = 0; i < n; i++) v = v | (32'(ref_mem[wrap(a, i)]) << (8 * i));
        return v;
    endfunction

    function automatic logic [AW-1:0] rand_addr();
        if ($urandom_range(0, 3) == 0) return AW'(MEM - 1 - $urandom_range(0, 2));
        return AW'($urandom_range(0, MEM - 1));
    endfunction

    task automatic check_reset_outputs(input string tag);
        chk({tag, "_ram_en"}, {31'd0, ram_en}, 32'd0);
        chk({tag, "_ram_r_nw"}, {31'd0, ram_r_nw}, 32'd1);
        chk({tag, "_ram_a"}, 32'(ram_a), 32'd0);
        chk({tag, "_ram_dout"}, 32'(ram_dout), 32'd0);
        chk({tag, "_if_done"}, {31'd0, if_done}, 32'd0);
        chk({tag, "_ls_done"}, {31'd0, ls_done}, 32'd0);
        chk({tag, "_if_data"}, if_data, 32'd0);
        chk({tag, "_ls_rdata"}, ls_rdata, 32'd0);
    endtask

    task automatic model_reset();
        last_ls = 1'b0;
        m_if_data = 32'd0;
        m_ls_rdata = 32'd0;
    endtask

    task automatic wait_until(input int c);
        while (cyc < c) @(negedge clk_in);
    endtask

    // single requester, held until its done; called and returns at a negedge
    task automatic do_txn(input bit is_ls, input bit we, input logic [1:0] size,
                          input logic [AW-1:0] addr, input logic [31:0] wdata);
        int a_edge = cyc + 1;
        int n = is_ls ? size_n(size) : 4;
        int d;
        exp_t e;
        if (is_ls && we) begin
            for (int i = 0; i < n; i++) ref_mem[wrap(addr, i)] = 8'(wdata >> (8 * i));
            d = a_edge + n;
        end else begin
            d = a_edge + n + 1;
            if (is_ls) m_ls_rdata = ref_read(addr, n);
            else       m_if_data  = ref_read(addr, n);
        end
        e = '{is_ls, m_if_data, m_ls_rdata, d};
        sbq.push_back(e);
        last_ls = is_ls;
        if (is_ls) begin
            ls_req = 1'b1; ls_we = we; ls_size = size; ls_addr = addr; ls_wdata = wdata;
        end else begin
            if_req = 1'b1; if_addr = addr;
        end
        wait_until(d);
        if_req = 1'b0;
        ls_req = 1'b0;
        @(negedge clk_in);
    endtask

    // both requesters held for count grants (loads only on the ls side)
    task automatic run_both(input int count, input logic [1:0] size,
                            input logic [AW-1:0] laddr, input logic [AW-1:0] faddr);
        int a_edge = cyc + 1;
        int d = 0;
        exp_t e;
        for (int k = 0; k < count; k++) begin
            bit w = !last_ls;
            int n = w ? size_n(size) : 4;
            d = a_edge + n + 1;
            if (w) m_ls_rdata = ref_read(laddr, n);
            else   m_if_data  = ref_read(faddr, 4);
            e = '{w, m_if_data, m_ls_rdata, d};
            sbq.push_back(e);
            last_ls = w;
            a_edge = d + 2;
        end
        ls_req = 1'b1; ls_we = 1'b0; ls_size = size; ls_addr = laddr;
        if_req = 1'b1; if_addr = faddr;
        wait_until(d);
        if_req = 1'b0;
        ls_req = 1'b0;
        @(negedge clk_in);
    endtask

    // fetch abandoned two cycles in; a load raised at the same time waits for the bus
    task automatic flush_test();
        int a_edge = cyc + 1;
        int n, d;
        logic [1:0] sz = 2'($urandom_range(0, 3));
        logic [AW-1:0] la = rand_addr();
        exp_t e;
        if_req = 1'b1; if_addr = rand_addr();
        wait_until(a_edge + 2);
        if_req = 1'b0;
        ls_req = 1'b1; ls_we = 1'b0; ls_size = sz; ls_addr = la;
        n = size_n(sz);
        d = a_edge + 6 + n + 1;
        m_ls_rdata = ref_read(la, n);
        e = '{1'b1, m_if_data, m_ls_rdata, d};
        sbq.push_back(e);
        last_ls = 1'b1;
        wait_until(a_edge + 6);
        chk("flush_if_data_held", if_data, m_if_data);
        wait_until(d);
        ls_req = 1'b0;
        @(negedge clk_in);
    endtask

    // word store interrupted by reset after two bytes have reached the RAM
    task automatic mid_store_reset();
        int a_edge = cyc + 1;
        logic [AW-1:0] addr = rand_addr();
        logic [31:0] wd;
        for (int i = 0; i < 4; i++) wd[8*i +: 8] = ~ref_mem[wrap(addr, i)];
        ls_req = 1'b1; ls_we = 1'b1; ls_size = 2'b10; ls_addr = addr; ls_wdata = wd;
        wait_until(a_edge + 1);
        rst_n_in = 1'b0;
        @(negedge clk_in);
        check_reset_outputs("midrst");
        rst_n_in = 1'b1;
        ls_req = 1'b0;
        model_reset();
        for (int i = 0; i < 2; i++) ref_mem[wrap(addr, i)] = wd[8*i +: 8];
        for (int i = 0; i < 4; i++) chk("midrst_ram_byte", 32'(ram[wrap(addr, i)]), 32'(ref_mem[wrap(addr, i)]));
        @(negedge clk_in);
    endtask

    initial begin
        int bad_bytes;
        for (int i = 0; i < MEM; i++) begin
            ram[i] = 8'($urandom);
            ref_mem[i] = ram[i];
        end
        repeat (3) @(negedge clk_in);
        check_reset_outputs("reset");
        rst_n_in = 1'b1;
        model_reset();
        @(negedge clk_in);

        // fetch of a known word
        ram[32'h100] = 8'h11; ram[32'h101] = 8'h22; ram[32'h102] = 8'h33; ram[32'h103] = 8'h44;
        ref_mem[32'h100] = 8'h11; ref_mem[32'h101] = 8'h22; ref_mem[32'h102] = 8'h33; ref_mem[32'h103] = 8'h44;
        do_txn(1'b0, 1'b0, 2'b10, AW'(32'h100), 32'd0);

        // wrapping word store then half load
        do_txn(1'b1, 1'b1, 2'b10, AW'(32'h1FFFE), 32'hDEADBEEF);
        do_txn(1'b1, 1'b0, 2'b01, AW'(32'h1FFFE), 32'd0);
        for (int i = 0; i < 4; i++) chk("wrap_store_byte", 32'(ram[wrap(AW'(32'h1FFFE), i)]), 32'(ref_mem[wrap(AW'(32'h1FFFE), i)]));

        // byte load at an odd address, no sign extension
        ram[7] = 8'h80; ref_mem[7] = 8'h80;
        do_txn(1'b1, 1'b0, 2'b00, AW'(7), 32'd0);

        mid_store_reset();
        run_both(4, 2'($urandom_range(0, 3)), rand_addr(), rand_addr());
        flush_test();

        for (int t = 0; t < 60; t++) begin
            int r = $urandom_range(0, 9);
            if (r <= 5) begin
                bit is_ls = 1'($urandom);
                do_txn(is_ls, is_ls & 1'($urandom), 2'($urandom_range(0, 3)), rand_addr(), $urandom);
            end else if (r <= 7) begin
                run_both($urandom_range(2, 4), 2'($urandom_range(0, 3)), rand_addr(), rand_addr());
            end else if (r == 8) begin
                flush_test();
            end else begin
                mid_store_reset();
            end
            repeat ($urandom_range(0, 2)) @(negedge clk_in);
        end

        repeat (10) @(negedge clk_in);
        chk("pending_expectations", sbq.size(), 32'd0);
        bad_bytes = 0;
        for (int i = 0; i < MEM; i++) if (ram[i] !== ref_mem[i]) bad_bytes++;
        chk("ram_image_bad_bytes", bad_bytes, 32'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation did not finish (cycle %0d)", cyc);
        $fatal(1, "watchdog");
    end

endmodule

// File: doc/mem_arbiter.md
MEM_ARBITER -- requirements
Module: mem_arbiter

Interface
REQ-001 SHALL have parameter ADDR_WIDTH, default 17, giving the RAM byte-address width (128 KB).
REQ-002 SHALL have port clk_in  input  1  system clock; all state updates on its rising edge.
REQ-003 SHALL have port rst_n_in  input  1  reset, synchronous and active-low.
REQ-004 SHALL have ports if_req input 1 and if_addr input ADDR_WIDTH: instruction-fetch request (always 4 bytes) and start byte address.
REQ-005 SHALL have ports if_done output 1 and if_data output 32: fetch-complete pulse and fetched word.
REQ-006 SHALL have ports ls_req input 1, ls_we input 1 (1 = store), ls_size input 2, ls_addr input ADDR_WIDTH and ls_wdata input 32 for the load/store requester.
REQ-007 SHALL have ports ls_done output 1 and ls_rdata output 32: load/store-complete pulse and load data.
REQ-008 SHALL have RAM-side ports ram_en output 1, ram_r_nw output 1 (1 = read), ram_a output ADDR_WIDTH, ram_dout output 8 (to RAM d_in) and ram_din input 8 (from RAM d_out; synchronous, valid the cycle after the address edge).

Function
REQ-009 SHALL implement the states IDLE, READ and WRITE, and SHALL serve exactly one transaction at a time.
REQ-010 SHALL decode the transfer length n from ls_size: 00 → 1 byte, 01 → 2 bytes, 10 or 11 → 4 bytes; a fetch always has n = 4.
REQ-011 SHALL, in IDLE with exactly one request high, accept that request at the edge; it SHALL latch address, n, we and wdata at that edge (the acceptance edge A).
REQ-012 SHALL arbitrate round-robin when both requests are high in IDLE: grant the requester not granted last; the last-grant flag resets to "fetch", so ls wins the first tie.
REQ-013 SHALL not accept a request during a cycle in which if_done or ls_done is high (one turnaround cycle), and SHALL return to IDLE at that same edge.
REQ-014 SHALL, for byte i (0..n-1), drive ram_a = (addr+i) mod 2^ADDR_WIDTH and ram_en = 1 during the cycle following edge A+i; addresses wrap silently and misalignment is permitted.
REQ-015 SHALL hold ram_en = 0 whenever no byte is being issued, and SHALL hold ram_r_nw = 1 except while issuing write bytes.
REQ-016 SHALL, on a read, capture ram_din for byte i at edge A+i+2 into bits [8i+7:8i] (little-endian), leaving unread upper bytes zero (no sign extension).
REQ-017 SHALL, on a read, assert the requester's done for exactly one cycle beginning at edge A+n+1, with the data output valid in that cycle; a word read therefore has 5-cycle latency.
REQ-018 SHALL, on a write, drive ram_r_nw = 0 and ram_dout = ls_wdata byte i with byte i's address, and SHALL assert ls_done for one cycle beginning at edge A+n.
REQ-019 SHALL hold if_data and ls_rdata at their last completed value until the next completion of the same requester.
REQ-020 SHALL, if if_req drops before if_done, finish the bus reads, suppress if_done, and leave if_data unchanged (fetch flush).
REQ-021 SHALL treat a dropped ls_req mid-transaction as don't-care: the access completes and ls_done still pulses; the requester must hold its inputs stable until done.

Reset
REQ-022 SHALL, on any edge with rst_n_in = 0, including mid-transaction, enter IDLE and abort the transaction, with no further RAM bytes written.
REQ-023 SHALL, on reset, force ram_en = 0, ram_r_nw = 1, ram_a = 0, ram_dout = 0, if_done = 0, ls_done = 0, if_data = 0, ls_rdata = 0 and last-grant = fetch.

Verification
REQ-024 SHALL cover a fetch: RAM[0x100..0x103] = 11,22,33,44 with if_req at 0x100 → if_data = 0x44332211 with if_done 5 cycles after acceptance, for exactly 1 cycle.
REQ-025 SHALL cover a store then load: store word 0xDEADBEEF at 0x1FFFE, then load half at 0x1FFFE → bytes written at 0x1FFFE, 0x1FFFF, 0x00000, 0x00001 (wrap), and ls_rdata = 0x0000BEEF.
REQ-026 SHALL cover contention: if_req and ls_req rise together from reset → ls served first, then fetch; both held again → grants alternate.
REQ-027 SHALL cover a fetch flush: if_req dropped 2 cycles after acceptance → no if_done pulse, if_data unchanged, a new ls_req accepted after the 4th byte read completes.
REQ-028 SHALL cover reset mid-store: rst_n_in low after 2 of 4 store bytes → only 2 bytes modified, all outputs at reset values next cycle.
REQ-029 SHALL cover a byte load: ls_size = 00 at odd address 0x00007 with RAM = 0x80 → ls_rdata = 0x00000080 with ls_done 2 cycles after acceptance.
